// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access controller: issues each load/store once on an SRAM-like
// bus, stalls the pipeline while outstanding, holds load data across stalls, drains flushed accesses.
module mem_access_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic        mem_wr,
    input  logic [1:0]  mem_size,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic        mem_except,
    input  logic        flush,
    input  logic        pipe_stall,
    output logic        data_req,
    output logic        data_wr,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok,
    input  logic [31:0] data_rdata,
    output logic        stall_mem,
    output logic [31:0] rdata_out
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        HOLD
    } state_t;

    state_t      state;
    state_t      state_next;
    logic        discard;
    logic        discard_next;
    logic        hold_load;
    logic        start;
    logic [31:0] hold_reg;
    logic        req_wr;
    logic [1:0]  req_size;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;

    assign start = mem_en & ~mem_except & ~flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            discard   <= 1'b0;
            hold_reg  <= '0;
            req_wr    <= 1'b0;
            req_size  <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state   <= state_next;
            discard <= discard_next;
            if (hold_load) begin
                hold_reg <= data_rdata;
            end
            if (state == IDLE && start) begin
                req_wr    <= mem_wr;
                req_size  <= mem_size;
                req_addr  <= mem_addr;
                req_wdata <= mem_wdata;
            end
        end
    end

    // NOTE: every signal written here gets a default first; a path that skips an
    // assignment would otherwise infer a latch.
    always_comb begin
        state_next   = state;
        discard_next = discard;
        hold_load    = 1'b0;
        data_req     = 1'b0;
        stall_mem    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    data_req   = 1'b1;
                    stall_mem  = 1'b1;
                    state_next = data_addr_ok ? DATA : ADDR;
                end
            end
            ADDR: begin
                // The request stays up even when flushed; the result is dropped later.
                data_req  = 1'b1;
                stall_mem = discard ? mem_en : 1'b1;
                if (flush) begin
                    discard_next = 1'b1;
                end
                if (data_addr_ok) begin
                    state_next = DATA;
                end
            end
            DATA: begin
                stall_mem = discard ? mem_en : ~data_data_ok;
                if (data_data_ok) begin
                    state_next   = IDLE;
                    discard_next = 1'b0;
                    if (!discard && !flush && pipe_stall) begin
                        hold_load  = 1'b1;
                        state_next = HOLD;
                    end
                end else if (flush) begin
                    discard_next = 1'b1;
                end
            end
            HOLD: begin
                if (!pipe_stall) begin
                    state_next = IDLE;
                end
            end
        endcase
    end

    // Bus fields pass through on the issue cycle, then come from the latched copy.
    assign data_wr    = (state == IDLE) ? mem_wr    : req_wr;
    assign data_size  = (state == IDLE) ? mem_size  : req_size;
    assign data_addr  = (state == IDLE) ? mem_addr  : req_addr;
    assign data_wdata = (state == IDLE) ? mem_wdata : req_wdata;

    assign rdata_out = (state == DATA) ? data_rdata : hold_reg;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: per-cycle vector table plus
// hand-written sequences for variable data latency and reset mid-transaction.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_en;
    logic        mem_wr;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_except;
    logic        flush;
    logic        pipe_stall;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_mem;
    logic [31:0] rdata_out;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .mem_en       (mem_en),
        .mem_wr       (mem_wr),
        .mem_size     (mem_size),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_except   (mem_except),
        .flush        (flush),
        .pipe_stall   (pipe_stall),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata),
        .stall_mem    (stall_mem),
        .rdata_out    (rdata_out)
    );

    // One record per clock cycle: inputs, then expected outputs with check enables.
    typedef struct {
        logic        en;
        logic        wr;
        logic [1:0]  sz;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        exc;
        logic        fl;
        logic        ps;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        e_req;
        logic        e_stall;
        logic        c_rd;
        logic [31:0] e_rd;
        logic        c_bus;
        logic [66:0] e_bus;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(input logic en, input logic wr, input logic [1:0] sz,
                               input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exc, input logic fl, input logic ps,
                               input logic aok, input logic dok, input logic [31:0] rd,
                               input logic e_req, input logic e_stall,
                               input logic c_rd, input logic [31:0] e_rd,
                               input logic c_bus, input logic [66:0] e_bus);
        vec_t r;
        r.en = en; r.wr = wr; r.sz = sz; r.addr = addr; r.wdata = wdata;
        r.exc = exc; r.fl = fl; r.ps = ps; r.aok = aok; r.dok = dok; r.rd = rd;
        r.e_req = e_req; r.e_stall = e_stall; r.c_rd = c_rd; r.e_rd = e_rd;
        r.c_bus = c_bus; r.e_bus = e_bus;
        return r;
    endfunction

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t t);
        mem_en       = t.en;
        mem_wr       = t.wr;
        mem_size     = t.sz;
        mem_addr     = t.addr;
        mem_wdata    = t.wdata;
        mem_except   = t.exc;
        flush        = t.fl;
        pipe_stall   = t.ps;
        data_addr_ok = t.aok;
        data_data_ok = t.dok;
        data_rdata   = t.rd;
    endtask

    task automatic idle_inputs();
        apply(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0));
    endtask

    function automatic logic [66:0] bus_now();
        return {data_wr, data_size, data_addr, data_wdata};
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          stall_cnt;
        int          hs;
        logic        done;
        logic [31:0] rd_at_ok;

        // Word load, addr_ok at issue, data_ok two cycles later.
        tbl.push_back(v('1, '0, 2'd2, 32'h80000010, '0, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '1, {1'b0, 2'd2, 32'h80000010, 32'h0}));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000010, '0, '0, '0, '0, '0, '0, '0, '0, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000010, '0, '0, '0, '0, '0, '1, 32'hDEADBEEF, '0, '0, '1, 32'hDEADBEEF, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, '0));
        // Byte store, addr_ok delayed 3 cycles; inputs disturbed to prove latched bus fields.
        tbl.push_back(v('1, '1, 2'd0, 32'h80000003, 32'h5A5A5A5A, '0, '0, '0, '0, '0, '0, '1, '1, '0, '0, '1, {1'b1, 2'd0, 32'h80000003, 32'h5A5A5A5A}));
        tbl.push_back(v('1, '1, 2'd2, 32'h00000FFF, '0, '0, '0, '0, '0, '0, '0, '1, '1, '0, '0, '1, {1'b1, 2'd0, 32'h80000003, 32'h5A5A5A5A}));
        tbl.push_back(v('1, '1, 2'd2, 32'h00000FFF, '0, '0, '0, '0, '0, '0, '0, '1, '1, '0, '0, '1, {1'b1, 2'd0, 32'h80000003, 32'h5A5A5A5A}));
        tbl.push_back(v('1, '1, 2'd2, 32'h00000FFF, '0, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '1, {1'b1, 2'd0, 32'h80000003, 32'h5A5A5A5A}));
        tbl.push_back(v('1, '1, 2'd0, 32'h80000003, 32'h5A5A5A5A, '0, '0, '0, '0, '1, '0, '0, '0, '0, '0, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, '0));
        // Load completing under pipe_stall: HOLD keeps the word, no re-issue.
        tbl.push_back(v('1, '0, 2'd2, 32'h80000020, '0, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000020, '0, '0, '0, '1, '0, '1, 32'h12345678, '0, '0, '1, 32'h12345678, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000020, '0, '0, '0, '1, '0, '0, 32'hFFFFFFFF, '0, '0, '1, 32'h12345678, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000020, '0, '0, '0, '1, '0, '0, 32'hFFFFFFFF, '0, '0, '1, 32'h12345678, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000020, '0, '0, '0, '0, '0, '0, 32'hFFFFFFFF, '0, '0, '1, 32'h12345678, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0));
        // Address exception and flush in IDLE suppress the access; stray data_ok ignored.
        tbl.push_back(v('1, '0, 2'd2, 32'h80000002, '0, '1, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000002, '0, '1, '0, '0, '0, '1, 32'h77777777, '0, '0, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000044, '0, '0, '1, '0, '0, '0, '0, '0, '0, '1, 32'h12345678, '0, '0));
        // Flush after addr_ok with a new store waiting: drain, then issue the store.
        tbl.push_back(v('1, '0, 2'd2, 32'h80000040, '0, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000040, '0, '0, '1, '0, '0, '0, '0, '0, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '1, 2'd2, 32'h80000080, 32'hCAFEF00D, '0, '0, '0, '0, '0, '0, '0, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '1, 2'd2, 32'h80000080, 32'hCAFEF00D, '0, '0, '1, '0, '1, 32'hBAD0BAD0, '0, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '1, 2'd2, 32'h80000080, 32'hCAFEF00D, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '1, {1'b1, 2'd2, 32'h80000080, 32'hCAFEF00D}));
        tbl.push_back(v('1, '1, 2'd2, 32'h80000080, 32'hCAFEF00D, '0, '0, '0, '0, '1, '0, '0, '0, '0, '0, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, 32'h12345678, '0, '0));
        // Flush coinciding with data_ok: dropped, no HOLD, discard stays clear.
        tbl.push_back(v('1, '0, 2'd2, 32'h80000100, '0, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000100, '0, '0, '1, '1, '0, '1, 32'h0BADF00D, '0, '0, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000104, '0, '0, '0, '0, '1, '0, '0, '1, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000104, '0, '0, '0, '0, '0, '1, 32'h11112222, '0, '0, '1, 32'h11112222, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, 32'h12345678, '0, '0));
        // Flush while the request is still pending in ADDR.
        tbl.push_back(v('1, '0, 2'd2, 32'h80000200, '0, '0, '0, '0, '0, '0, '0, '1, '1, '0, '0, '0, '0));
        tbl.push_back(v('1, '0, 2'd2, 32'h80000200, '0, '0, '1, '0, '0, '0, '0, '1, '1, '0, '0, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '1, '0, '0, '1, '0, '0, '0, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '1, 32'h99999999, '0, '0, '0, '0, '0, '0));
        tbl.push_back(v('0, '0, 2'd0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '0, '1, 32'h12345678, '1, '0));

        rst = 1'b1;
        idle_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_req", {66'b0, data_req}, 67'd0);
        check("reset_stall", {66'b0, stall_mem}, 67'd0);
        check("reset_bus", bus_now(), 67'd0);
        check("reset_rdata", {35'b0, rdata_out}, 67'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < tbl.size(); i++) begin
            apply(tbl[i]);
            @(negedge clk);
            check($sformatf("v%0d_req", i), {66'b0, data_req}, {66'b0, tbl[i].e_req});
            check($sformatf("v%0d_stall", i), {66'b0, stall_mem}, {66'b0, tbl[i].e_stall});
            if (tbl[i].c_rd) begin
                check($sformatf("v%0d_rdata", i), {35'b0, rdata_out}, {35'b0, tbl[i].e_rd});
            end
            if (tbl[i].c_bus) begin
                check($sformatf("v%0d_bus", i), bus_now(), tbl[i].e_bus);
            end
            @(posedge clk);
            #1;
        end

        // Variable data latency: stall lasts exactly lat cycles, one handshake.
        lat       = $urandom_range(1, 5);
        stall_cnt = 0;
        hs        = 0;
        done      = 1'b0;
        rd_at_ok  = '0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            apply(v('1, '0, 2'd2, 32'h80000300, '0, '0, '0, '0, logic'(cyc == 0), logic'(cyc == lat),
                    32'hA5A50000 | 32'(lat), '0, '0, '0, '0, '0, '0));
            @(negedge clk);
            if (stall_mem) stall_cnt++;
            if (data_req && data_addr_ok) hs++;
            if (cyc == lat) rd_at_ok = rdata_out;
            if (!stall_mem) done = 1'b1;
            @(posedge clk);
            #1;
            if (done) break;
        end
        check("lat_done", {66'b0, done}, {66'b0, 1'b1});
        check("lat_stall_cycles", 67'(stall_cnt), 67'(lat));
        check("lat_handshakes", 67'(hs), 67'd1);
        check("lat_rdata", {35'b0, rd_at_ok}, {35'b0, 32'hA5A50000 | 32'(lat)});
        idle_inputs();
        @(posedge clk);
        #1;

        // Reset asserted while the load waits in DATA.
        apply(v('1, '0, 2'd2, 32'h80000400, '0, '0, '0, '0, '1, '0, '0, '0, '0, '0, '0, '0, '0));
        @(posedge clk);
        #1;
        data_addr_ok = 1'b0;
        rst          = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);
        check("rst_data_req", {66'b0, data_req}, 67'd0);
        check("rst_data_stall", {66'b0, stall_mem}, 67'd0);
        check("rst_data_rdata", {35'b0, rdata_out}, 67'd0);
        check("rst_data_bus", bus_now(), 67'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
